// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: one command in, one SETUP/ACCESS transfer out,
// one held response back. A pready-less ACCESS phase is aborted after TIMEOUT cycles.
module apb_master_bridge #(
   parameter int ADDR_W        = 8,
   parameter int DATA_W        = 8,
   parameter int TIMEOUT       = 16,
   parameter int RD_SAMPLE_DLY = 1
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RDLAG,
      S_RESP
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_q;
   logic                psel_q, penable_q, pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic                rsp_valid_q, rsp_write_q, rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic                accept;

   // A new command may only start once any pending response is gone or leaving now.
   assign cmd_ready = (state_q == S_IDLE) && (!rsp_valid_q || rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign cnt_d     = cnt_q + 1'b1;

   assign busy      = (state_q != S_IDLE);
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         if (rsp_valid_q && rsp_ready)
            rsp_valid_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q   <= S_SETUP;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  pwrite_q  <= cmd_write;
                  paddr_q   <= cmd_addr;
                  pwdata_q  <= cmd_wdata;
                  err_q     <= 1'b0;
                  rdata_q   <= '0;
               end
            end
            S_SETUP: begin
               state_q   <= S_ACCESS;
               penable_q <= 1'b1;
               cnt_q     <= '0;
            end
            S_ACCESS: begin
               if (pready) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  if (!pwrite_q && (RD_SAMPLE_DLY != 0)) begin
                     state_q <= S_RDLAG;
                  end else begin
                     state_q <= S_RESP;
                     if (!pwrite_q)
                        rdata_q <= prdata;
                  end
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  // Counter holds its final value; it is cleared again in SETUP.
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  err_q     <= 1'b1;
                  state_q   <= S_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RDLAG: begin
               rdata_q <= prdata;
               state_q <= S_RESP;
            end
            S_RESP: begin
               rsp_valid_q <= 1'b1;
               rsp_write_q <= pwrite_q;
               rsp_err_q   <= err_q;
               rsp_rdata_q <= err_q ? '0 : rdata_q;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Random command stream against a transaction-level model: expected data, status,
// latency and APB phase counts are derived from the wait-state count of each transfer.
module tb_apb_master_bridge;
   localparam int TIMEOUT = 16;
   localparam int RD_DLY  = 1;

   logic       pclk, presetn;
   logic       cmd_valid, cmd_ready, cmd_write;
   logic [7:0] cmd_addr, cmd_wdata;
   logic       rsp_valid, rsp_ready, rsp_write, rsp_err, busy;
   logic [7:0] rsp_rdata;
   logic       psel, penable, pwrite, pready;
   logic [7:0] paddr, pwdata, prdata;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   int         wait_n, acc_cnt;
   int         checks, errors;

   apb_master_bridge #(
      .ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT), .RD_SAMPLE_DLY(RD_DLY)
   ) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Slave: pready after wait_n ACCESS cycles, random pready elsewhere, and read data
   // that only becomes correct in the cycle after the pready cycle.
   initial begin
      pready  = 1'b0;
      prdata  = 8'h00;
      acc_cnt = 0;
      forever begin
         @(negedge pclk);
         if (psel && penable) begin
            pready = (acc_cnt == wait_n);
            if (pready) begin
               acc_cnt = 0;
               if (pwrite) mem[paddr] = pwdata;
               prdata = ~mem[paddr];
            end else begin
               acc_cnt++;
               prdata = mem[paddr];
            end
         end else begin
            acc_cnt = 0;
            pready  = 1'($urandom_range(0, 1));
            prdata  = mem[paddr];
         end
      end
   end

   // Presents a command and returns at the first negedge after it was accepted.
   task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d, input int waits);
      int n;
      wait_n    = waits;
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      #1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge pclk);
         #1;
         n++;
      end
      chk("cmd_ready", 32'(cmd_ready), 1);
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = 8'($urandom);
   endtask

   task automatic run_txn(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input int waits, input int hold);
      int n, ps, pe, acc, lat;
      logic [7:0] er;
      logic ee;
      ee  = (waits >= TIMEOUT);
      acc = ee ? TIMEOUT : waits + 1;
      lat = 3 + acc + ((!wr && !ee && RD_DLY != 0) ? 1 : 0);
      er  = (wr || ee) ? 8'h00 : ref_mem[a];
      if (wr && !ee) ref_mem[a] = d;

      issue(wr, a, d, waits);
      chk("rsp_clr", 32'(rsp_valid), 0);
      chk("busy", 32'(busy), 1);
      n = 1; ps = 0; pe = 0;
      while (!rsp_valid && n < 40) begin
         ps += int'(psel);
         pe += int'(penable);
         @(negedge pclk);
         n++;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("psel_cyc", 32'(ps), 32'(acc + 1));
      chk("pen_cyc", 32'(pe), 32'(acc));
      chk("rsp_write", 32'(rsp_write), 32'(wr));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(er));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      chk("idle_after", 32'(busy), 0);

      if (hold > 0) begin
         rsp_ready = 1'b0;
         cmd_valid = 1'b1;
         for (int k = 0; k < hold; k++) begin
            #1;
            chk("stall_rdy", 32'(cmd_ready), 0);
            chk("stall_vld", 32'(rsp_valid), 1);
            chk("stall_rd", 32'(rsp_rdata), 32'(er));
            chk("stall_err", 32'(rsp_err), 32'(ee));
            chk("stall_psel", 32'(psel), 0);
            @(negedge pclk);
         end
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
   endtask

   initial begin
      int w, r, hold;
      checks    = 0;
      errors    = 0;
      presetn   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      rsp_ready = 1'b1;
      wait_n    = 0;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge pclk);
      #1;
      chk("rst_psel", 32'(psel), 0);
      chk("rst_penable", 32'(penable), 0);
      chk("rst_pwrite", 32'(pwrite), 0);
      chk("rst_paddr", 32'(paddr), 0);
      chk("rst_pwdata", 32'(pwdata), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_write", 32'(rsp_write), 0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
      chk("rst_busy", 32'(busy), 0);
      presetn = 1'b1;
      @(negedge pclk);

      run_txn(1'b1, 8'h05, 8'h3C, 0, 0);
      run_txn(1'b0, 8'h05, 8'h00, 0, 0);
      run_txn(1'b0, 8'h05, 8'h00, 100, 0);
      run_txn(1'b1, 8'h22, 8'h5A, TIMEOUT, 0);
      run_txn(1'b0, 8'h22, 8'h00, TIMEOUT - 1, 0);
      run_txn(1'b1, 8'h07, 8'hA5, 1, 10);
      run_txn(1'b0, 8'h07, 8'h00, 0, 0);

      // Reset in the middle of a stalled write: nothing may commit or respond.
      issue(1'b1, 8'h30, 8'hEE, 100);
      @(negedge pclk);
      chk("rst_pre_pen", 32'(penable), 1);
      presetn = 1'b0;
      @(negedge pclk);
      chk("rst_mid_psel", 32'(psel), 0);
      chk("rst_mid_pen", 32'(penable), 0);
      chk("rst_mid_vld", 32'(rsp_valid), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      presetn = 1'b1;
      @(negedge pclk);
      chk("rst_mid_vld2", 32'(rsp_valid), 0);
      run_txn(1'b0, 8'h30, 8'h00, 0, 0);

      for (int t = 0; t < 60; t++) begin
         r    = int'($urandom_range(0, 9));
         w    = (r < 6) ? int'($urandom_range(0, 3)) :
                (r < 8) ? int'($urandom_range(4, 15)) : int'($urandom_range(16, 30));
         hold = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0;
         run_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), w, hold);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
